// File: rtl/gray_updown_counter.sv
// Up/down Gray-code counter with synchronous load, wrap-or-saturate terminal
// behaviour, and sticky overflow/underflow flags cleared by FlagClr.
module gray_updown_counter #(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Bin,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Terminal
);

  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] bin_s;
  logic             at_max_s, at_zero_s;
  logic             ovf_set_s, unf_set_s;

  // Decode the held Gray state and detect the terminal counts.
  always_comb begin
    bin_s     = gray_to_bin(gray_q);
    at_max_s  = (bin_s == MAX_VAL);
    at_zero_s = (bin_s == ZERO_VAL);
  end

  // Next state: load beats counting; terminal steps raise a flag and wrap or hold.
  always_comb begin
    gray_d    = gray_q;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (Load) begin
      gray_d = LoadVal;
    end else if (En) begin
      if (!Dir) begin
        if (at_max_s) begin
          ovf_set_s = 1'b1;
          if (WRAP) begin
            gray_d = ZERO_VAL;
          end else begin
            gray_d = gray_q;
          end
        end else begin
          gray_d = bin_to_gray(bin_s + ONE_VAL);
        end
      end else begin
        if (at_zero_s) begin
          unf_set_s = 1'b1;
          if (WRAP) begin
            gray_d = bin_to_gray(MAX_VAL);
          end else begin
            gray_d = gray_q;
          end
        end else begin
          gray_d = bin_to_gray(bin_s - ONE_VAL);
        end
      end
    end else begin
      gray_d = gray_q;
    end
  end

  // Sticky flags: a set event in the same cycle overrides FlagClr.
  always_comb begin
    ovf_d = FlagClr ? 1'b0 : ovf_q;
    unf_d = FlagClr ? 1'b0 : unf_q;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (unf_set_s) begin
      unf_d = 1'b1;
    end else begin
      unf_d = unf_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      gray_q <= ZERO_VAL;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Terminal looks at the direction being requested right now.
  always_comb begin
    Output    = gray_q;
    Bin       = bin_s;
    Overflow  = ovf_q;
    Underflow = unf_q;
    Terminal  = Dir ? at_zero_s : at_max_s;
  end

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits, legal range 2..16.
REQ-002 Parameter WRAP, default 1: 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; Reset=0 forces the reset state immediately, independent of Clk.
REQ-005 En  input  1  count enable; 1 = advance one step per Clk edge.
REQ-006 Dir  input  1  count direction; 0 = up, 1 = down.
REQ-007 Load  input  1  synchronous load strobe.
REQ-008 LoadVal  input  WIDTH  Gray-coded value captured when Load=1.
REQ-009 FlagClr  input  1  synchronous clear of the sticky flags.
REQ-010 Output  output  WIDTH  registered Gray-code count.
REQ-011 Bin  output  WIDTH  combinational binary equivalent of Output.
REQ-012 Overflow  output  1  registered sticky flag: an up-count reached past the maximum.
REQ-013 Underflow  output  1  registered sticky flag: a down-count reached past zero.
REQ-014 Terminal  output  1  combinational: 1 when (Dir=0 and Bin = 2^WIDTH-1) or (Dir=1 and Bin = 0).

Function
REQ-015 Output SHALL follow the reflected binary Gray sequence: Output = B ^ (B >> 1), where B is the internal binary count.
REQ-016 Bin SHALL equal the Gray-to-binary conversion of Output: Bin[WIDTH-1] = Output[WIDTH-1]; Bin[i] = Bin[i+1] ^ Output[i].
REQ-017 Per-edge priority SHALL be: Load, then En; En=0 and Load=0 holds Output.
REQ-018 Load=1 SHALL set Output to LoadVal on the next edge, regardless of En and Dir, and SHALL leave the flags unchanged.
REQ-019 En=1, Dir=0, Bin below maximum SHALL advance to the next Gray code (binary +1).
REQ-020 En=1, Dir=1, Bin above 0 SHALL step to the previous Gray code (binary -1).
REQ-021 Every En-driven step that changes Output SHALL change exactly one bit.
REQ-022 Up-count at Bin = 2^WIDTH-1 SHALL set Overflow=1; Output SHALL go to 0 when WRAP=1 and hold when WRAP=0.
REQ-023 Down-count at Bin = 0 SHALL set Underflow=1; Output SHALL go to Gray(2^WIDTH-1) when WRAP=1 and hold when WRAP=0.
REQ-024 Overflow and Underflow SHALL remain set until FlagClr=1 or reset.
REQ-025 FlagClr=1 SHALL clear both flags on the next edge, except that a flag set event in the same cycle wins: that flag ends the cycle at 1.
REQ-026 When Load=1 and FlagClr=1 in the same cycle, both SHALL take effect.
REQ-027 A direction change SHALL take effect on the next edge with no dead cycle.

Reset
REQ-028 Reset=0 SHALL asynchronously force Output=0, Overflow=0 and Underflow=0; Bin=0 follows combinationally.
REQ-029 Reset asserted mid-count SHALL discard the in-progress step; no flag SHALL survive reset.
REQ-030 After Reset deasserts, the first counting edge SHALL produce the first step from 0.

Verification (WIDTH=3)
REQ-031 Reset, then En=1, Dir=0 for 8 edges -> Output = 001,011,010,110,111,101,100,000; Overflow=1 after the 8th edge; Underflow=0.
REQ-032 From reset, En=1, Dir=1 for 1 edge, WRAP=1 -> Output=100, Bin=111, Underflow=1; with WRAP=0 -> Output=000, Underflow=1.
REQ-033 Load=1, LoadVal=110, En=1, Dir=0 -> Output=110 (load wins); next edge with En=1 -> 111; Bin = 100 then 101.
REQ-034 Overflow=1, FlagClr=1 with no wrap -> Overflow=0 next edge; FlagClr=1 on the wrap edge 100->000 -> Overflow stays 1.
REQ-035 Reset pulled low between edges at Output=111 with Overflow=1 -> Output=000 and Overflow=0 before the next Clk edge.
REQ-036 Random En/Dir/Load for 10^4 cycles against a binary reference model -> Bin matches, single-bit change on every counting step, and Terminal is correct every cycle.
